// File: rtl/id_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// id_ctrl_pipe -- ID-stage control for the 5-stage RV32 pipeline.
//
// Decodes the ID instruction opcode into EX/MEM/WB controls. It detects
// load-use hazards against the instruction currently in ID/EX, and holds the
// registered ID/EX control pipeline register.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   instr_valid   ID instruction is real (not a bubble)
//   instr[31:0]   ID-stage instruction
//   flush         branch/jump redirect, kills the ID instruction
//   ex_alu_op     10 R-type, 01 BEQ, 00 add
//   ex_alu_src    1 selects the immediate
//   ex_branch     BEQ
//   ex_jump       JAL/JALR
//   ex_mem_read   load
//   ex_mem_write  store
//   ex_reg_write  writes rd
//   ex_wb_sel     00 ALU, 01 memory, 10 PC+4
//   ex_rd/rs1/rs2 registered instr[11:7], [19:15], [24:20]
//   ex_valid      ID/EX holds a real instruction
//   ex_illegal    ID/EX holds an undecodable instruction
//   stall         combinational load-use stall
//   pc_write      ~stall, to IF
//   if_id_write   ~stall, to IF/ID
// ---------------------------------------------------------------------------
module id_ctrl_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int EN_JUMP    = 1,
  parameter int EN_LUI     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  input  logic                  flush,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic [1:0]            ex_wb_sel,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic                  ex_valid,
  output logic                  ex_illegal,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  if_id_write
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
  } ctrl_t;

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  valid;
    logic                  illegal;
  } idex_t;

  ctrl_t                 dec;
  logic                  illegal;
  logic                  use_rs1;
  logic                  use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  hazard;
  logic                  cnt_busy;
  logic [CNT_W-1:0]      cnt;
  idex_t                 idex;

  // funct3/funct7 do not affect control here; fold them into a sink.
  logic unused_bits;
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  assign id_rd  = REG_ADDR_W'(instr[11:7]);
  assign id_rs1 = REG_ADDR_W'(instr[19:15]);
  assign id_rs2 = REG_ADDR_W'(instr[24:20]);

  // Opcode decode.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path can leave one unassigned and infer a latch.
    dec     = '0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (instr[6:0])
      OP_R: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_LW: begin
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_sel    = 2'b01;
        use_rs1       = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = 2'b01;
        dec.branch = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        use_rs1       = 1'b1;
      end
      OP_LUI: begin
        if (EN_LUI != 0) begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        if (EN_JUMP != 0) begin
          dec.jump      = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_sel    = 2'b10;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EN_JUMP != 0) begin
          dec.jump      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_sel    = 2'b10;
          use_rs1       = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load-use hazard: the load in EX cannot forward its data in time for a
  // dependent ID instruction. x0 never carries a dependency.
  assign hazard = instr_valid & idex.valid & idex.ctrl.mem_read &
                  (idex.rd != '0) &
                  ((use_rs1 & (id_rs1 == idex.rd)) |
                   (use_rs2 & (id_rs2 == idex.rd)));

  // cnt holds the remaining stall cycles after the first one, so a hazard
  // seen with cnt==0 already stalls in that same cycle.
  assign cnt_busy    = (cnt != '0);
  assign stall       = ~flush & (cnt_busy | hazard);
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  // ID/EX register and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      idex <= '0;
      cnt  <= '0;
    end else if (flush) begin
      idex <= '0;
      cnt  <= '0;
    end else if (stall) begin
      idex <= '0;
      if (cnt_busy) cnt <= cnt - CNT_W'(1);
      else          cnt <= CNT_W'(LOAD_LAT - 1);
    end else begin
      idex.ctrl    <= instr_valid ? dec : '0;
      idex.rd      <= id_rd;
      idex.rs1     <= id_rs1;
      idex.rs2     <= id_rs2;
      idex.valid   <= instr_valid;
      idex.illegal <= illegal & instr_valid;
    end
  end

  assign ex_alu_op    = idex.ctrl.alu_op;
  assign ex_alu_src   = idex.ctrl.alu_src;
  assign ex_branch    = idex.ctrl.branch;
  assign ex_jump      = idex.ctrl.jump;
  assign ex_mem_read  = idex.ctrl.mem_read;
  assign ex_mem_write = idex.ctrl.mem_write;
  assign ex_reg_write = idex.ctrl.reg_write;
  assign ex_wb_sel    = idex.ctrl.wb_sel;
  assign ex_rd        = idex.rd;
  assign ex_rs1       = idex.rs1;
  assign ex_rs2       = idex.rs2;
  assign ex_valid     = idex.valid;
  assign ex_illegal   = idex.illegal;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ctrl_pipe -- scoreboard bench for id_ctrl_pipe.
//
// Three instances share one stimulus stream:
//   dut 0: LOAD_LAT=1, jumps and LUI enabled
//   dut 1: LOAD_LAT=3, jumps and LUI enabled
//   dut 2: LOAD_LAT=2, jumps and LUI disabled
// The stimulus process runs a behavioural model per instance and queues the
// expected outputs of every cycle. The monitor pops and compares them on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_id_ctrl_pipe;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       valid;
    logic       illegal;
  } ex_t;

  typedef struct packed {
    logic [1:0] k;
    logic       chk;
    logic       stall;
    ex_t        ex;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;

  logic [1:0] o_alu_op    [3];
  logic       o_alu_src   [3];
  logic       o_branch    [3];
  logic       o_jump      [3];
  logic       o_mem_read  [3];
  logic       o_mem_write [3];
  logic       o_reg_write [3];
  logic [1:0] o_wb_sel    [3];
  logic [4:0] o_rd        [3];
  logic [4:0] o_rs1       [3];
  logic [4:0] o_rs2       [3];
  logic       o_valid     [3];
  logic       o_illegal   [3];
  logic       o_stall     [3];
  logic       o_pc_write  [3];
  logic       o_if_id_write [3];
  ex_t        act         [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_ctrl_pipe #(
      .REG_ADDR_W (5),
      .LOAD_LAT   (g == 0 ? 1 : (g == 1 ? 3 : 2)),
      .EN_JUMP    (g == 2 ? 0 : 1),
      .EN_LUI     (g == 2 ? 0 : 1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .flush        (flush),
      .ex_alu_op    (o_alu_op[g]),
      .ex_alu_src   (o_alu_src[g]),
      .ex_branch    (o_branch[g]),
      .ex_jump      (o_jump[g]),
      .ex_mem_read  (o_mem_read[g]),
      .ex_mem_write (o_mem_write[g]),
      .ex_reg_write (o_reg_write[g]),
      .ex_wb_sel    (o_wb_sel[g]),
      .ex_rd        (o_rd[g]),
      .ex_rs1       (o_rs1[g]),
      .ex_rs2       (o_rs2[g]),
      .ex_valid     (o_valid[g]),
      .ex_illegal   (o_illegal[g]),
      .stall        (o_stall[g]),
      .pc_write     (o_pc_write[g]),
      .if_id_write  (o_if_id_write[g])
    );
    assign act[g] = {o_alu_op[g], o_alu_src[g], o_branch[g], o_jump[g],
                     o_mem_read[g], o_mem_write[g], o_reg_write[g],
                     o_wb_sel[g], o_rd[g], o_rs1[g], o_rs2[g],
                     o_valid[g], o_illegal[g]};
  end

  // ---------------- scoreboard bookkeeping ----------------
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  bit   mon_on  = 1'b0;
  bit   m_known = 1'b0;
  ex_t  m_ex   [3];
  int   m_left [3];

  task automatic check(input string nm, input int k,
                       input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, a, e);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  // Reference decode, straight from the opcode table.
  function automatic ex_t ref_decode(input logic [31:0] ins, input bit ej,
                                     input bit el, output bit u1, output bit u2);
    ex_t d = '0;
    u1 = 1'b0;
    u2 = 1'b0;
    d.rd    = ins[11:7];
    d.rs1   = ins[19:15];
    d.rs2   = ins[24:20];
    d.valid = 1'b1;
    case (ins[6:0])
      7'b0110011: begin d.alu_op = 2'b10; d.reg_write = 1; u1 = 1; u2 = 1; end
      7'b0000011: begin d.alu_src = 1; d.mem_read = 1; d.reg_write = 1;
                        d.wb_sel = 2'b01; u1 = 1; end
      7'b0100011: begin d.alu_src = 1; d.mem_write = 1; u1 = 1; u2 = 1; end
      7'b1100011: begin d.alu_op = 2'b01; d.branch = 1; u1 = 1; u2 = 1; end
      7'b0010011: begin d.alu_src = 1; d.reg_write = 1; u1 = 1; end
      7'b0110111: if (el) begin d.alu_src = 1; d.reg_write = 1; end
                  else d.illegal = 1;
      7'b1101111: if (ej) begin d.jump = 1; d.reg_write = 1; d.wb_sel = 2'b10; end
                  else d.illegal = 1;
      7'b1100111: if (ej) begin d.jump = 1; d.alu_src = 1; d.reg_write = 1;
                                d.wb_sel = 2'b10; u1 = 1; end
                  else d.illegal = 1;
      default: d.illegal = 1;
    endcase
    return d;
  endfunction

  // One cycle of the behavioural model for instance k: outputs seen this
  // cycle are queued, then the state for the next cycle is computed.
  task automatic model_step(input int k, input logic r, input logic v,
                            input logic [31:0] ins, input logic f);
    ex_t  cur = m_ex[k];
    ex_t  d;
    bit   u1, u2, hz, st;
    exp_t item;
    d  = ref_decode(ins, k != 2, k != 2, u1, u2);
    hz = v && cur.valid && cur.mem_read && (cur.rd != 0) &&
         ((u1 && ins[19:15] == cur.rd) || (u2 && ins[24:20] == cur.rd));
    st = !f && (m_left[k] > 0 || hz);
    item.k     = 2'(k);
    item.chk   = m_known;
    item.stall = st;
    item.ex    = cur;
    q.push_back(item);
    if (r) begin
      m_ex[k] = '0; m_left[k] = 0;
    end else if (f) begin
      m_ex[k] = '0; m_left[k] = 0;
    end else if (m_left[k] > 0) begin
      m_ex[k] = '0; m_left[k]--;
    end else if (hz) begin
      m_ex[k] = '0; m_left[k] = lat_of(k) - 1;
    end else begin
      if (!v) begin
        d = '0;
        d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
      end
      m_ex[k] = d;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic f);
    @(posedge clk);
    #1;
    rst = r; instr_valid = v; instr = ins; flush = f;
    for (int k = 0; k < 3; k++) model_step(k, r, v, ins, f);
    if (r) m_known = 1'b1;
    mon_on = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int n = 0; n < 3; n++) begin
          if (q.size() == 0) begin
            check("queue_underflow", n, 1, 0);
          end else begin
            int k;
            it = q.pop_front();
            k  = int'(it.k);
            if (it.chk) begin
              check("stall",       k, 32'(o_stall[k]),       32'(it.stall));
              check("pc_write",    k, 32'(o_pc_write[k]),    32'(!it.stall));
              check("if_id_write", k, 32'(o_if_id_write[k]), 32'(!it.stall));
              check("alu_op",    k, 32'(act[k].alu_op),    32'(it.ex.alu_op));
              check("alu_src",   k, 32'(act[k].alu_src),   32'(it.ex.alu_src));
              check("branch",    k, 32'(act[k].branch),    32'(it.ex.branch));
              check("jump",      k, 32'(act[k].jump),      32'(it.ex.jump));
              check("mem_read",  k, 32'(act[k].mem_read),  32'(it.ex.mem_read));
              check("mem_write", k, 32'(act[k].mem_write), 32'(it.ex.mem_write));
              check("reg_write", k, 32'(act[k].reg_write), 32'(it.ex.reg_write));
              check("wb_sel",    k, 32'(act[k].wb_sel),    32'(it.ex.wb_sel));
              check("ex_valid",  k, 32'(act[k].valid),     32'(it.ex.valid));
              check("ex_illegal",k, 32'(act[k].illegal),   32'(it.ex.illegal));
              if (it.ex.valid) begin
                check("ex_rd",  k, 32'(act[k].rd),  32'(it.ex.rd));
                check("ex_rs1", k, 32'(act[k].rs1), 32'(it.ex.rs1));
                check("ex_rs2", k, 32'(act[k].rs2), 32'(it.ex.rs2));
              end
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADDI   = 32'h0010_8093;
  localparam logic [31:0] LW_X5  = 32'h0000_A283;
  localparam logic [31:0] ADD_D  = 32'h0022_8333;  // add x6,x5,x2
  localparam logic [31:0] LW_X0  = 32'h0000_A003;
  localparam logic [31:0] ADD_X0 = 32'h0020_0333;  // add x6,x0,x2
  localparam logic [31:0] ADD_I  = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] JAL    = 32'h0080_00EF;

  logic [6:0] ops [9];

  initial begin
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
            7'b0110111, 7'b1101111, 7'b1100111, 7'b0001111};
    for (int k = 0; k < 3; k++) begin m_ex[k] = '0; m_left[k] = 0; end

    // Reset held, then ADDI.
    step(1, 1, ADDI, 0);
    step(1, 1, ADDI, 0);
    step(0, 1, ADDI, 0);
    step(0, 0, 32'h0, 0);

    // Load-use: dependent ADD held in ID while stalled.
    step(0, 1, LW_X5, 0);
    repeat (4) step(0, 1, ADD_D, 0);
    step(0, 0, 32'h0, 0);

    // Flush in the second stall cycle.
    step(0, 1, LW_X5, 0);
    step(0, 1, ADD_D, 0);
    step(0, 1, ADD_D, 1);
    repeat (3) step(0, 1, ADD_D, 0);
    step(0, 0, 32'h0, 0);

    // No-stall cases: x0 destination and an independent consumer.
    step(0, 1, LW_X0, 0);
    step(0, 1, ADD_X0, 0);
    step(0, 1, LW_X5, 0);
    step(0, 1, ADD_I, 0);

    // Illegal, jumps, LUI, store, branch.
    step(0, 1, 32'hFFFF_FFFF, 0);
    step(0, 1, JAL, 0);
    step(0, 1, 32'h0000_80E7, 0);  // jalr x1,0(x1)
    step(0, 1, 32'h1234_50B7, 0);  // lui x1
    step(0, 1, 32'h0020_A023, 0);  // sw x2,0(x1)
    step(0, 1, 32'h0020_8063, 0);  // beq x1,x2
    step(0, 0, 32'hFFFF_FFFF, 0);  // invalid slot carrying junk

    // Reset asserted mid-stall.
    step(0, 1, LW_X5, 0);
    step(0, 1, ADD_D, 0);
    step(1, 1, ADD_D, 0);
    repeat (2) step(0, 1, ADD_D, 0);

    // Random traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [6:0]  op;
      op  = ops[$urandom_range(0, 8)];
      ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             3'($urandom), 5'($urandom_range(0, 3)), op};
      if ($urandom_range(0, 9) == 0) ins = $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), ins,
           ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    #1;
    mon_on = 1'b0;
    check("queue_drain", 0, 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
